uart_tx_arbiter: RTL and testbench

Shares one UART transmitter core among NUM_REQ requesters. Each requester sends byte-wide packets with valid/ready/last. Arbitration is round-robin at packet granularity: a grant is held until the byte flagged last is transmitted. The block sits between the command/echo logic in uart_allocation and the tx serializer. It sequences the serializer with a start/done handshake, inserts an idle gap between packets, and drops a grant whose owner stalls too long.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/rr_pick.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: byte width, baud timing,
// arbiter state encoding and a width helper for saturating counters.
package uart_pkg;

  localparam int DATA_W       = 8;
  localparam int CLK_FREQ     = 100_000_000;
  localparam int BAUD         = 9600;
  localparam int CLKS_PER_BIT = (CLK_FREQ + BAUD / 2) / BAUD;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_GAP       = 2'd3;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int bits_for(input int max_val);
    int w;
    w = 1;
    while ((longint'(1) << w) <= longint'(max_val)) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first set request at or above ptr,
// wrapping around, returned as one-hot grant plus binary index.
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] idx,
  output logic            any_req
);

  function automatic logic [ID_W-1:0] wrap_idx(input int v);
    return ID_W'(v % N);
  endfunction

  // NOTE: every output gets a default before the search loop so no latch is inferred.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any_req && req[wrap_idx(int'(ptr) + i)]) begin
        any_req                         = 1'b1;
        idx                             = wrap_idx(int'(ptr) + i);
        grant[wrap_idx(int'(ptr) + i)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of a shared UART serializer,
// with an inter-packet idle gap and a stall timeout on the granted owner.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = uart_pkg::DATA_W,
  parameter int GAP_CLKS     = uart_pkg::CLKS_PER_BIT,
  parameter int TIMEOUT_CLKS = 1_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data_i,
  input  logic [NUM_REQ-1:0]          req_last_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]           tx_data_o,
  output logic                        tx_start_o,
  input  logic                        tx_busy_i,
  input  logic                        tx_done_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        busy_o,
  output logic                        timeout_o,
  output logic [$clog2(NUM_REQ)-1:0]  timeout_id_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int GAP_W = bits_for(GAP_CLKS);
  localparam int TO_W  = bits_for(TIMEOUT_CLKS);

  logic [1:0]         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    owner;
  logic               last_q;
  logic [GAP_W-1:0]   gap_cnt;
  logic [TO_W-1:0]    to_cnt;

  logic [NUM_REQ-1:0] pick_grant;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  req_data_arr [NUM_REQ];
  logic               owner_valid;
  logic               fire;
  logic               stall_step;
  logic               stall_expire;
  logic [ID_W-1:0]    next_ptr;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign req_data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
    .req     (req_valid_i),
    .ptr     (rr_ptr),
    .grant   (pick_grant),
    .idx     (pick_idx),
    .any_req (pick_any)
  );

  assign owner_valid  = req_valid_i[owner];
  assign fire         = (state == ST_LOAD) && owner_valid && !tx_busy_i;
  // A busy serializer freezes the stall count rather than advancing it.
  assign stall_step   = (state == ST_LOAD) && !owner_valid && !tx_busy_i;
  assign stall_expire = stall_step && (to_cnt >= TO_W'(TIMEOUT_CLKS - 1));
  assign next_ptr     = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
  assign busy_o       = (state != ST_IDLE);

  always_comb begin
    req_ready_o = '0;
    if (state == ST_LOAD) req_ready_o[owner] = owner_valid && !tx_busy_i;
  end

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      owner        <= '0;
      last_q       <= 1'b0;
      gap_cnt      <= '0;
      to_cnt       <= '0;
      grant_o      <= '0;
      tx_data_o    <= '0;
      tx_start_o   <= 1'b0;
      timeout_o    <= 1'b0;
      timeout_id_o <= '0;
    end else begin
      tx_start_o <= 1'b0;
      timeout_o  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_o <= pick_grant;
            owner   <= pick_idx;
            to_cnt  <= '0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (fire) begin
            tx_data_o  <= req_data_arr[owner];
            last_q     <= req_last_i[owner];
            tx_start_o <= 1'b1;
            to_cnt     <= '0;
            state      <= ST_WAIT_DONE;
          end else if (owner_valid) begin
            to_cnt <= '0;
          end else if (stall_expire) begin
            timeout_o    <= 1'b1;
            timeout_id_o <= owner;
            grant_o      <= '0;
            rr_ptr       <= next_ptr;
            to_cnt       <= '0;
            gap_cnt      <= '0;
            state        <= (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
          end else if (stall_step) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done_i) begin
            if (last_q) begin
              grant_o <= '0;
              rr_ptr  <= next_ptr;
              gap_cnt <= '0;
              state   <= (GAP_CLKS > 0) ? ST_GAP : ST_IDLE;
            end else begin
              to_cnt <= '0;
              state  <= ST_LOAD;
            end
          end
        end
        default: begin
          if (gap_cnt >= GAP_W'(GAP_CLKS - 1)) begin
            gap_cnt <= '0;
            state   <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: queued requester packets, a behavioural serializer and
// a round-robin packet-order model computed from the queued traffic.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 5;
  localparam int TMO = 50;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } ent_t;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid_i = '0;
  logic [N*8-1:0] req_data_i = '0;
  logic [N-1:0]   req_last_i = '0;
  logic [N-1:0]   req_ready_o;
  logic [7:0]     tx_data_o;
  logic           tx_start_o;
  logic           tx_busy_i = 1'b0;
  logic           tx_done_i = 1'b0;
  logic [N-1:0]   grant_o;
  logic           busy_o;
  logic           timeout_o;
  logic [1:0]     timeout_id_o;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_W(8), .GAP_CLKS(GAP), .TIMEOUT_CLKS(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_last_i(req_last_i),
    .req_ready_o(req_ready_o), .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
    .tx_busy_i(tx_busy_i), .tx_done_i(tx_done_i), .grant_o(grant_o),
    .busy_o(busy_o), .timeout_o(timeout_o), .timeout_id_o(timeout_id_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ent_t       rq [N][$];
  logic [7:0] log_data[$];
  int         log_own[$];
  int         log_start[$];
  int         log_done[$];
  logic [7:0] exp_data[$];
  int         exp_own[$];
  logic       exp_last[$];
  int         first_ready[N];
  int         to_cyc, to_id, to_grant, to_count;
  int         nonowner_ready, busy_ready, multi_grant;
  logic       man_busy = 1'b0;
  logic       ser_busy = 1'b0;
  int         ser_cnt, ser_fixed;
  int         model_ptr;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  // One clock: observe registered outputs, run the serializer, drive requesters,
  // then sample the combinational ready that the next edge will act on.
  task automatic step();
    int k;
    @(negedge clk);
    if (!reset) begin
      ser_busy  = 1'b0;
      ser_cnt   = 0;
      tx_done_i = 1'b0;
      while (log_done.size() < log_start.size()) log_done.push_back(-1);
    end else begin
      if (tx_start_o) begin
        k = onehot_idx(grant_o);
        log_data.push_back(tx_data_o);
        log_own.push_back(k);
        log_start.push_back(cyc);
        if (k >= 0 && rq[k].size() > 0) void'(rq[k].pop_front());
        ser_busy  = 1'b1;
        ser_cnt   = (ser_fixed > 0) ? ser_fixed : int'($urandom_range(1, 4));
        tx_done_i = 1'b0;
      end else if (tx_done_i) begin
        tx_done_i = 1'b0;
      end else if (ser_busy) begin
        if (ser_cnt == 0) begin
          ser_busy  = 1'b0;
          tx_done_i = 1'b1;
          log_done.push_back(cyc);
        end else begin
          ser_cnt--;
        end
      end
      if (timeout_o) begin
        to_count++;
        to_cyc   = cyc;
        to_id    = int'(timeout_id_o);
        to_grant = int'(grant_o);
      end
    end
    for (int r = 0; r < N; r++) begin
      if (rq[r].size() > 0) begin
        req_valid_i[r]       = 1'b1;
        req_data_i[r*8 +: 8] = rq[r][0].data;
        req_last_i[r]        = rq[r][0].last;
      end else begin
        req_valid_i[r]       = 1'b0;
        req_data_i[r*8 +: 8] = 8'($urandom);
        req_last_i[r]        = 1'($urandom);
      end
    end
    tx_busy_i = ser_busy | man_busy;
    #1;
    for (int r = 0; r < N; r++) if (req_ready_o[r] && first_ready[r] < 0) first_ready[r] = cyc;
    if ((req_ready_o & ~grant_o) != '0) nonowner_ready++;
    if (req_ready_o != '0 && tx_busy_i) busy_ready++;
    if ($countones(grant_o) > 1) multi_grant++;
  endtask

  // Expected byte order: whole packets, next owner searched upward from the pointer.
  task automatic model_build();
    ent_t cp [N][$];
    ent_t e;
    int   k;
    bit   found;
    for (int r = 0; r < N; r++) cp[r] = rq[r];
    while (1) begin
      found = 1'b0;
      for (int i = 0; i < N && !found; i++) begin
        k = (model_ptr + i) % N;
        if (cp[k].size() > 0) begin
          do begin
            e = cp[k].pop_front();
            exp_own.push_back(k);
            exp_data.push_back(e.data);
            exp_last.push_back(e.last);
          end while (!e.last && cp[k].size() > 0);
          model_ptr = (k + 1) % N;
          found = 1'b1;
        end
      end
      if (!found) break;
    end
  endtask

  task automatic push_exp(input int own, input logic [7:0] d, input logic l);
    exp_own.push_back(own);
    exp_data.push_back(d);
    exp_last.push_back(l);
  endtask

  task automatic run_until_idle(input int target, input string tag);
    int b;
    b = 0;
    while ((log_start.size() < target || busy_o) && b < 3000) begin
      step();
      b++;
    end
    check({tag, " finished within budget"}, 32'(b < 3000), 32'd1);
  endtask

  task automatic compare_range(input int base, input string tag, input bit timing);
    int want;
    check({tag, " byte count"}, 32'(log_start.size()), 32'(exp_own.size()));
    for (int i = base; i < exp_own.size() && i < log_start.size(); i++) begin
      check($sformatf("%s byte%0d owner", tag, i - base), 32'(log_own[i]), 32'(exp_own[i]));
      check($sformatf("%s byte%0d data", tag, i - base), 32'(log_data[i]), 32'(exp_data[i]));
      if (timing && i > base && log_done.size() >= i) begin
        want = exp_last[i-1] ? GAP + 3 : 2;
        check($sformatf("%s byte%0d start spacing", tag, i - base),
              32'(log_start[i] - log_done[i-1]), 32'(want));
      end
    end
  endtask

  task automatic clear_ready();
    for (int r = 0; r < N; r++) first_ready[r] = -1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    for (int r = 0; r < N; r++) rq[r].delete();
    repeat (3) step();
    reset = 1'b1;
    model_ptr = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " grant_o"},      32'(grant_o), 32'd0);
    check({tag, " tx_data_o"},    32'(tx_data_o), 32'd0);
    check({tag, " tx_start_o"},   32'(tx_start_o), 32'd0);
    check({tag, " req_ready_o"},  32'(req_ready_o), 32'd0);
    check({tag, " busy_o"},       32'(busy_o), 32'd0);
    check({tag, " timeout_o"},    32'(timeout_o), 32'd0);
    check({tag, " timeout_id_o"}, 32'(timeout_id_o), 32'd0);
  endtask

  initial begin
    int base, rel, total, npk, len, b;
    ser_fixed = 0;
    model_ptr = 0;
    to_count = 0;
    nonowner_ready = 0;
    busy_ready = 0;
    multi_grant = 0;
    clear_ready();

    #1 reset = 1'b0;
    #1 check_zero_outputs("reset");
    repeat (3) step();
    reset = 1'b1;

    // Single two-byte packet from requester 0.
    base = log_start.size();
    rq[0].push_back('{1'b0, 8'h81});
    rq[0].push_back('{1'b1, 8'h26});
    model_build();
    run_until_idle(base + 2, "single");
    compare_range(base, "single", 1'b1);
    if (log_data.size() >= base + 2) begin
      check("single first byte", 32'(log_data[base]), 32'h81);
      check("single second byte", 32'(log_data[base+1]), 32'h26);
    end

    // Pointer moved past requester 0: requester 1 wins a tie with 0.
    base = log_start.size();
    rq[0].push_back('{1'b1, 8'h30});
    rq[1].push_back('{1'b1, 8'h31});
    model_build();
    run_until_idle(base + 2, "ptr");
    compare_range(base, "ptr", 1'b1);
    if (log_own.size() > base) check("ptr first owner", 32'(log_own[base]), 32'd1);

    // Contention from pointer 0: 0, then 2, then 0's second packet.
    do_reset();
    base = log_start.size();
    rq[0].push_back('{1'b1, 8'h11});
    rq[0].push_back('{1'b1, 8'h12});
    rq[2].push_back('{1'b1, 8'h21});
    model_build();
    run_until_idle(base + 3, "contend");
    compare_range(base, "contend", 1'b1);
    if (log_own.size() >= base + 3) begin
      check("contend owner0", 32'(log_own[base]), 32'd0);
      check("contend owner1", 32'(log_own[base+1]), 32'd2);
      check("contend owner2", 32'(log_own[base+2]), 32'd0);
    end

    // Packet atomicity: requester 3 waits for the whole packet plus gap.
    clear_ready();
    base = log_start.size();
    rq[1].push_back('{1'b0, 8'h10});
    rq[1].push_back('{1'b0, 8'h20});
    rq[1].push_back('{1'b1, 8'h30});
    rq[3].push_back('{1'b1, 8'h3F});
    model_build();
    run_until_idle(base + 4, "atomic");
    compare_range(base, "atomic", 1'b1);
    if (log_done.size() >= base + 3)
      check("atomic req3 first ready", 32'(first_ready[3]), 32'(log_done[base+2] + GAP + 2));

    // Stall timeout: requester 2 abandons its packet after one byte.
    clear_ready();
    to_count = 0;
    base = log_start.size();
    rq[2].push_back('{1'b0, 8'h88});
    rq[3].push_back('{1'b1, 8'h99});
    push_exp(2, 8'h88, 1'b0);
    push_exp(3, 8'h99, 1'b1);
    model_ptr = 0;
    run_until_idle(base + 2, "stall");
    compare_range(base, "stall", 1'b0);
    check("stall timeout pulses", 32'(to_count), 32'd1);
    check("stall timeout id", 32'(to_id), 32'd2);
    check("stall grant at timeout", 32'(to_grant), 32'd0);
    if (log_done.size() > base)
      check("stall timeout cycle", 32'(to_cyc), 32'(log_done[base] + 1 + TMO));
    check("stall req3 first ready", 32'(first_ready[3]), 32'(to_cyc + GAP + 1));

    // Serializer busy in LOAD blocks the handshake until released.
    clear_ready();
    man_busy = 1'b1;
    base = log_start.size();
    rq[0].push_back('{1'b1, 8'h5A});
    push_exp(0, 8'h5A, 1'b1);
    model_ptr = 1;
    repeat (10) step();
    check("busy no start", 32'(log_start.size()), 32'(base));
    check("busy no ready", 32'(first_ready[0]), 32'hFFFF_FFFF);
    check("busy still owned", 32'(grant_o), 32'b0001);
    man_busy = 1'b0;
    step();
    rel = cyc;
    check("busy release ready", 32'(first_ready[0]), 32'(rel));
    run_until_idle(base + 1, "busy");
    compare_range(base, "busy", 1'b0);
    if (log_start.size() > base) check("busy start latency", 32'(log_start[base]), 32'(rel + 1));

    // Randomized packets on every requester.
    base = log_start.size();
    total = 0;
    for (int r = 0; r < N; r++) begin
      npk = int'($urandom_range(1, 3));
      for (int p = 0; p < npk; p++) begin
        len = int'($urandom_range(1, 4));
        for (int i = 0; i < len; i++) begin
          rq[r].push_back('{1'(i == len - 1), 8'($urandom)});
          total++;
        end
      end
    end
    model_build();
    run_until_idle(base + total, "random");
    compare_range(base, "random", 1'b1);

    // Async reset while a byte is in flight; afterwards arbitration restarts at 0.
    base = log_start.size();
    rq[1].push_back('{1'b1, 8'hA1});
    model_build();
    run_until_idle(base + 1, "prereset");
    compare_range(base, "prereset", 1'b0);
    ser_fixed = 20;
    base = log_start.size();
    rq[2].push_back('{1'b0, 8'hB1});
    rq[2].push_back('{1'b1, 8'hB2});
    push_exp(2, 8'hB1, 1'b0);
    b = 0;
    while (log_start.size() < base + 1 && b < 500) begin
      step();
      b++;
    end
    check("midreset start seen", 32'(b < 500), 32'd1);
    repeat (3) step();
    check("midreset in flight", 32'(busy_o), 32'd1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 check_zero_outputs("midreset");
    for (int r = 0; r < N; r++) rq[r].delete();
    ser_fixed = 0;
    repeat (2) step();
    reset = 1'b1;
    model_ptr = 0;
    base = log_start.size();
    rq[3].push_back('{1'b1, 8'hC3});
    rq[1].push_back('{1'b1, 8'hC1});
    model_build();
    run_until_idle(base + 2, "postreset");
    compare_range(base, "postreset", 1'b0);
    if (log_own.size() > base) check("postreset first owner", 32'(log_own[base]), 32'd1);

    check("non-owner ready cycles", 32'(nonowner_ready), 32'd0);
    check("ready while busy cycles", 32'(busy_ready), 32'd0);
    check("multi-hot grant cycles", 32'(multi_grant), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
